// File: rtl/cheri_trvk_stage_pkg.sv
// rtl/cheri_trvk_stage_pkg.sv - shared constants and types for the CLC revocation stage
package cheri_trvk_stage_pkg;

   localparam logic [6:0] NullParBits = 7'h2a;

   // Each tsmap bit covers one 8B granule, so one 32-bit word covers 256B.
   localparam int unsigned GranuleLog2 = 3;
   localparam int unsigned WordBits    = 32;
   localparam int unsigned WordLog2    = 5;
   localparam int unsigned WordBytes   = WordBits << GranuleLog2;

   typedef struct packed {
      logic       en;
      logic       clrtag;
      logic [4:0] addr;
      logic [6:0] par;
   } trvk_req_t;

   function automatic logic [WordLog2-1:0] granule_bit(input logic [31:0] base);
      return base[GranuleLog2 +: WordLog2];
   endfunction

endpackage

// File: rtl/prim_secded_inv_39_32_enc.sv
// rtl/prim_secded_inv_39_32_enc.sv - inverted Hsiao SECDED(39,32) encoder
module prim_secded_inv_39_32_enc (
   input  logic [31:0] data_i,
   output logic [38:0] data_o
);

   logic [6:0] ecc;

   assign ecc[0] = ^(data_i & 32'h2606_BD25);
   assign ecc[1] = ^(data_i & 32'hDEBA_8050);
   assign ecc[2] = ^(data_i & 32'h413D_89AA);
   assign ecc[3] = ^(data_i & 32'h3123_4ED1);
   assign ecc[4] = ^(data_i & 32'hC2C1_323B);
   assign ecc[5] = ^(data_i & 32'h2DCC_624C);
   assign ecc[6] = ^(data_i & 32'h9850_5586);

   // Inversion makes an all-zero word a detectable error.
   assign data_o = {ecc ^ 7'h2a, data_i};

endmodule

// File: rtl/cheri_trvk_stage.sv
// rtl/cheri_trvk_stage.sv - CLC tag reservation / revocation stage between LSU and regfile
module cheri_trvk_stage
   import cheri_trvk_stage_pkg::*;
#(
   parameter logic [31:0] HeapBase   = 32'h8000_0000,
   parameter int unsigned TSMapSize  = 1024,
   parameter bit          CheriPPLBC = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_clc_req_done_i,
   input  logic [4:0]  lsu_clc_waddr_i,
   input  logic        lsu_resp_valid_i,
   input  logic        lsu_resp_is_clc_i,
   input  logic        lsu_resp_err_i,
   input  logic [4:0]  lsu_resp_waddr_i,
   input  logic        lsu_resp_tag_i,
   input  logic [31:0] lsu_resp_base_i,
   output logic        tsmap_cs_o,
   output logic [15:0] tsmap_addr_o,
   input  logic [31:0] tsmap_rdata_i,
   output logic        trsv_en_o,
   output logic [4:0]  trsv_addr_o,
   output logic [6:0]  trsv_par_o,
   output logic        trvk_en_o,
   output logic        trvk_clrtag_o,
   output logic [4:0]  trvk_addr_o,
   output logic [6:0]  trvk_par_o,
   output logic        alert_o
);

   localparam logic [31:0] TSMapBytes = 32'(TSMapSize * WordBytes);

   logic        clc_rsp, in_rng, lookup;
   logic [31:0] off;
   logic        trsv_en;
   trvk_req_t   trvk;
   logic [38:0] trsv_cw, trvk_cw;
   logic        unused_cw;

   logic        s1_vld_q, s1_vld_d;
   logic [4:0]  s1_addr_q, s1_addr_d;
   logic        s1_lkp_q, s1_lkp_d;
   logic [4:0]  s1_bit_q, s1_bit_d;
   logic [31:0] pend_q, pend_d;
   logic        alert_q, alert_d;

   assign trsv_en = CheriPPLBC & lsu_clc_req_done_i & (lsu_clc_waddr_i != 5'd0);

   assign clc_rsp = lsu_resp_valid_i & lsu_resp_is_clc_i & (lsu_resp_waddr_i != 5'd0);
   assign off     = lsu_resp_base_i - HeapBase;
   assign in_rng  = (lsu_resp_base_i >= HeapBase) & (off < TSMapBytes);
   assign lookup  = CheriPPLBC & clc_rsp & ~lsu_resp_err_i & lsu_resp_tag_i & in_rng;

   assign tsmap_cs_o   = lookup;
   assign tsmap_addr_o = lookup ? off[23:8] : 16'h0;

   prim_secded_inv_39_32_enc u_trsv_enc (
      .data_i ({26'h0, trsv_en, lsu_clc_waddr_i}),
      .data_o (trsv_cw)
   );

   assign trvk.en     = CheriPPLBC & s1_vld_q;
   assign trvk.addr   = s1_addr_q;
   assign trvk.clrtag = trvk.en & s1_lkp_q & tsmap_rdata_i[s1_bit_q];

   prim_secded_inv_39_32_enc u_trvk_enc (
      .data_i ({25'h0, trvk.en, trvk.clrtag, trvk.addr}),
      .data_o (trvk_cw)
   );

   assign trvk.par  = trvk_cw[38:32];
   assign unused_cw = ^{trsv_cw[31:0], trvk_cw[31:0]};

   assign trsv_en_o     = trsv_en;
   assign trsv_addr_o   = CheriPPLBC ? lsu_clc_waddr_i : 5'd0;
   assign trsv_par_o    = CheriPPLBC ? trsv_cw[38:32] : 7'd0;
   assign trvk_en_o     = trvk.en;
   assign trvk_clrtag_o = trvk.clrtag;
   assign trvk_addr_o   = CheriPPLBC ? trvk.addr : 5'd0;
   assign trvk_par_o    = CheriPPLBC ? trvk.par : 7'd0;
   assign alert_o       = alert_q;

   always_comb begin
      s1_vld_d  = clc_rsp;
      s1_addr_d = lsu_resp_waddr_i;
      s1_lkp_d  = lookup;
      s1_bit_d  = granule_bit(lsu_resp_base_i);

      // Release before reserve so a same-register trsv in the trvk cycle keeps the bit set.
      pend_d = pend_q;
      if (trvk.en) pend_d[trvk.addr] = 1'b0;
      if (trsv_en) pend_d[lsu_clc_waddr_i] = 1'b1;
      pend_d[0] = 1'b0;

      alert_d = CheriPPLBC &
                ((trvk.en & ~pend_q[trvk.addr]) |
                 (trsv_en & pend_q[lsu_clc_waddr_i] &
                  ~(trvk.en & (trvk.addr == lsu_clc_waddr_i))));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_vld_q  <= 1'b0;
         s1_addr_q <= 5'd0;
         s1_lkp_q  <= 1'b0;
         s1_bit_q  <= 5'd0;
         pend_q    <= 32'd0;
         alert_q   <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_addr_q <= s1_addr_d;
         s1_lkp_q  <= s1_lkp_d;
         s1_bit_q  <= s1_bit_d;
         pend_q    <= pend_d;
         alert_q   <= alert_d;
      end
   end

endmodule
